// File: rtl/jtag_prog_pkg.sv
// ============================================================================
// jtag_prog_pkg -- shared PROG/CTRL data-register layout for jtag_prog_dr
// Rev 1.0
// ============================================================================
`default_nettype none

package jtag_prog_pkg;

   // PROG DR: bit0 = we, then the address field, then the data field on top.
   localparam int c_prog_we_bit   = 0;
   localparam int c_prog_addr_lsb = 1;

   localparam int c_ctrl_w       = 2;
   localparam int c_ctrl_en_bit  = 0;
   localparam int c_ctrl_clr_bit = 1;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_PROG = 2'd1,
      SEL_CTRL = 2'd2
   } dr_sel_e;

   function automatic int prog_pw(input int aw, input int dw);
      return 1 + aw + dw;
   endfunction

   function automatic int prog_data_lsb(input int aw);
      return c_prog_addr_lsb + aw;
   endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_prog_dr_if.sv
// ============================================================================
// jtag_prog_dr_if -- TCK-domain request bus toward the programming controller
// Rev 1.0
// ============================================================================
`default_nettype none

interface jtag_prog_dr_if #(
   parameter int MEM_ADDR_WIDTH = 6,
   parameter int MEM_DATA_WIDTH = 32
);
   logic                      jtag_en;
   logic                      jtag_req_pulse;
   logic                      jtag_we;
   logic [MEM_ADDR_WIDTH-1:0] jtag_addr;
   logic [MEM_DATA_WIDTH-1:0] jtag_wdata;
   logic [MEM_DATA_WIDTH-1:0] jtag_rdata;

   modport master (
      output jtag_en, jtag_req_pulse, jtag_we, jtag_addr, jtag_wdata,
      input  jtag_rdata
   );

   modport slave (
      input  jtag_en, jtag_req_pulse, jtag_we, jtag_addr, jtag_wdata,
      output jtag_rdata
   );
endinterface

`default_nettype wire

// File: rtl/jtag_shift_reg.sv
// ============================================================================
// jtag_shift_reg -- generic capture/shift data register, LSB shifted out first
// Rev 1.0
// ============================================================================
`default_nettype none

module jtag_shift_reg #(
   parameter int W = 2
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic         i_load,
   input  wire logic [W-1:0] i_load_val,
   input  wire logic         i_shift,
   input  wire logic         i_sin,
   output logic              o_bit0,
   output logic      [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_load_val;
      end else if (i_shift) begin
         r_q <= {i_sin, r_q[W-1:1]};
      end
   end

   assign o_bit0 = r_q[0];
   assign o_q    = r_q;

endmodule

`default_nettype wire

// File: rtl/jtag_prog_dr.sv
// ============================================================================
// jtag_prog_dr -- JTAG PROG/CTRL data registers issuing memory requests
// Rev 1.0
// ============================================================================
`default_nettype none

module jtag_prog_dr
   import jtag_prog_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = 6,
   parameter int MEM_DATA_WIDTH = 32,
   parameter int REQ_GAP        = 8
) (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       tdi,
   output logic            tdo,
   input  wire logic       capture_dr,
   input  wire logic       shift_dr,
   input  wire logic       update_dr,
   input  wire logic       sel_ctrl,
   input  wire logic       sel_prog,
   jtag_prog_dr_if.master  prog_bus
);

   localparam int c_pw       = prog_pw(MEM_ADDR_WIDTH, MEM_DATA_WIDTH);
   localparam int c_data_lsb = prog_data_lsb(MEM_ADDR_WIDTH);
   localparam int c_gw       = $clog2(REQ_GAP + 1);

   dr_sel_e                   w_sel;
   logic                      w_upd;
   logic                      w_cap;
   logic                      w_shf;
   logic                      w_busy;
   logic                      w_pbit0;
   logic                      w_cbit0;
   logic [c_pw-1:0]           w_psh;
   logic [c_ctrl_w-1:0]       w_csh;

   logic                      r_en;
   logic                      r_err;
   logic                      r_req;
   logic                      r_we;
   logic [MEM_ADDR_WIDTH-1:0] r_addr;
   logic [MEM_DATA_WIDTH-1:0] r_wdata;
   logic [c_gw-1:0]           r_gap;

   always_comb begin
      w_sel = SEL_NONE;
      if (sel_prog) begin
         w_sel = SEL_PROG;
      end else if (sel_ctrl) begin
         w_sel = SEL_CTRL;
      end
   end

   // Update outranks capture, capture outranks shift.
   assign w_upd  = update_dr;
   assign w_cap  = capture_dr & ~update_dr;
   assign w_shf  = shift_dr & ~update_dr & ~capture_dr;
   assign w_busy = (r_gap != '0);

   jtag_shift_reg #(.W(c_pw)) u_prog_sr (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_cap && (w_sel == SEL_PROG)),
      .i_load_val ({prog_bus.jtag_rdata, r_addr, w_busy}),
      .i_shift    (w_shf && (w_sel == SEL_PROG)),
      .i_sin      (tdi),
      .o_bit0     (w_pbit0),
      .o_q        (w_psh)
   );

   jtag_shift_reg #(.W(c_ctrl_w)) u_ctrl_sr (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_cap && (w_sel == SEL_CTRL)),
      .i_load_val ({r_err, r_en}),
      .i_shift    (w_shf && (w_sel == SEL_CTRL)),
      .i_sin      (tdi),
      .o_bit0     (w_cbit0),
      .o_q        (w_csh)
   );

   always_comb begin
      tdo = 1'b0;
      case (w_sel)
         SEL_PROG: tdo = w_pbit0;
         SEL_CTRL: tdo = w_cbit0;
         default:  tdo = 1'b0;
      endcase
   end

   // addr/wdata move only on an accepted update so the CPU side can sample
   // them as a stable bundle on the synchronised request pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_en    <= 1'b0;
         r_err   <= 1'b0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_gap   <= '0;
      end else begin
         r_req <= 1'b0;
         r_we  <= 1'b0;
         if (w_busy) begin
            r_gap <= r_gap - c_gw'(1);
         end
         if (w_upd && (w_sel == SEL_CTRL)) begin
            r_en <= w_csh[c_ctrl_en_bit];
            if (w_csh[c_ctrl_clr_bit]) begin
               r_err <= 1'b0;
            end
         end
         if (w_upd && (w_sel == SEL_PROG)) begin
            if (r_en && !w_busy) begin
               r_addr  <= w_psh[c_prog_addr_lsb +: MEM_ADDR_WIDTH];
               r_wdata <= w_psh[c_data_lsb +: MEM_DATA_WIDTH];
               r_req   <= 1'b1;
               r_we    <= w_psh[c_prog_we_bit];
               r_gap   <= c_gw'(REQ_GAP);
            end else begin
               r_err <= 1'b1;
            end
         end
      end
   end

   assign prog_bus.jtag_en        = r_en;
   assign prog_bus.jtag_req_pulse = r_req;
   assign prog_bus.jtag_we        = r_we;
   assign prog_bus.jtag_addr      = r_addr;
   assign prog_bus.jtag_wdata     = r_wdata;

endmodule

`default_nettype wire
